// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 SEQ front end: instruction codes, ALU function
// codes, condition codes, register specifiers, instruction lengths and small helpers.
package y86_pkg;

    // Instruction codes (upper nibble of byte 0)
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // ALU function codes (ifun of OPq)
    typedef enum logic [1:0] {
        AluAdd = 2'd0,
        AluSub = 2'd1,
        AluAnd = 2'd2,
        AluXor = 2'd3
    } alu_fn_e;

    // Condition codes (ifun of jXX / cmovXX)
    localparam logic [3:0] C_ALL = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    // Register specifiers
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    // Instruction lengths in bytes
    localparam logic [3:0] LEN_1  = 4'd1;
    localparam logic [3:0] LEN_2  = 4'd2;
    localparam logic [3:0] LEN_9  = 4'd9;
    localparam logic [3:0] LEN_10 = 4'd10;

    // Length implied by the icode alone; unknown icodes occupy one byte.
    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        logic [3:0] len;
        len = LEN_1;
        case (icode)
            IHALT, INOP, IRET:              len = LEN_1;
            IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:   len = LEN_2;
            IIRMOVQ, IRMMOVQ, IMRMOVQ:      len = LEN_10;
            IJXX, ICALL:                    len = LEN_9;
            default:                        len = LEN_1;
        endcase
        return len;
    endfunction

    // Branch / conditional-move predicate from the registered flags.
    function automatic logic cond_eval(input logic [3:0] ifun, input logic zf,
                                       input logic sf, input logic of);
        logic c;
        c = 1'b0;
        case (ifun)
            C_ALL:   c = 1'b1;
            C_LE:    c = (sf ^ of) | zf;
            C_L:     c = sf ^ of;
            C_E:     c = zf;
            C_NE:    c = ~zf;
            C_GE:    c = ~(sf ^ of);
            C_G:     c = ~(sf ^ of) & ~zf;
            default: c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/y86_alu.sv
// 64-bit Y86 ALU.
// Ports:
//   alu_a, alu_b  in  64  operands; subtraction computes alu_b - alu_a
//   fn            in      add / sub / and / xor
//   result        out 64  modulo-2^64 result
//   of, sf, zf    out 1   overflow, sign and zero of the result
module y86_alu
    import y86_pkg::*;
(
    input  logic [63:0] alu_a,
    input  logic [63:0] alu_b,
    input  alu_fn_e     fn,
    output logic [63:0] result,
    output logic        of,
    output logic        sf,
    output logic        zf
);

    always_comb begin
        result = 64'd0;
        of     = 1'b0;
        unique case (fn)
            AluAdd: begin
                result = alu_b + alu_a;
                of     = (alu_a[63] == alu_b[63]) && (result[63] != alu_a[63]);
            end
            AluSub: begin
                result = alu_b - alu_a;
                of     = (alu_a[63] != alu_b[63]) && (result[63] != alu_b[63]);
            end
            AluAnd: result = alu_b & alu_a;
            AluXor: result = alu_b ^ alu_a;
            default: begin
                result = 64'd0;
                of     = 1'b0;
            end
        endcase
    end

    assign sf = result[63];
    assign zf = (result == 64'd0);

endmodule

// File: rtl/y86_seq_fde.sv
// Fetch / decode / execute front end of the single-cycle Y86-64 SEQ processor.
// Holds the byte-addressed instruction memory and the condition-code register.
// Ports:
//   clock, reset_n                     clock and asynchronous active-low reset (CC only)
//   imem_we, imem_waddr, imem_wdata    program-load byte write; out-of-range addresses dropped
//   pc_counter                         address of the current instruction
//   r0..r14                            register file values (r4 = rsp)
//   icode, ifun, ra, rb, valc, valp    fetched fields
//   vala, valb                         decoded operands
//   vale, condition_cnd                ALU result and branch/cmov condition
//   overflow_flag, sign_flag, zero_flag registered condition codes
//   instruction_valid, imem_error, halt status
module y86_seq_fde
    import y86_pkg::*;
#(
    parameter int unsigned IMEM_BYTES = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        imem_we,
    input  logic [63:0] imem_waddr,
    input  logic [7:0]  imem_wdata,
    input  logic [63:0] pc_counter,
    input  logic [63:0] r0,
    input  logic [63:0] r1,
    input  logic [63:0] r2,
    input  logic [63:0] r3,
    input  logic [63:0] r4,
    input  logic [63:0] r5,
    input  logic [63:0] r6,
    input  logic [63:0] r7,
    input  logic [63:0] r8,
    input  logic [63:0] r9,
    input  logic [63:0] r10,
    input  logic [63:0] r11,
    input  logic [63:0] r12,
    input  logic [63:0] r13,
    input  logic [63:0] r14,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  ra,
    output logic [3:0]  rb,
    output logic [63:0] valc,
    output logic [63:0] valp,
    output logic [63:0] vala,
    output logic [63:0] valb,
    output logic [63:0] vale,
    output logic        condition_cnd,
    output logic        overflow_flag,
    output logic        sign_flag,
    output logic        zero_flag,
    output logic        instruction_valid,
    output logic        imem_error,
    output logic        halt
);

    localparam int unsigned AW         = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
    localparam logic [64:0] IMEM_LIMIT = 65'(IMEM_BYTES);

    // ---------------------------------------------------------------- instruction memory
    logic [7:0] imem [IMEM_BYTES];

    always_ff @(posedge clock) begin
        if (imem_we && ({1'b0, imem_waddr} < IMEM_LIMIT)) begin
            imem[imem_waddr[AW-1:0]] <= imem_wdata;
        end
    end

    // ---------------------------------------------------------------- fetch
    // Up to ten bytes starting at pc; bytes past the end of memory read as zero.
    logic [7:0] fbyte [10];

    always_comb begin
        for (int i = 0; i < 10; i++) begin
            if (({1'b0, pc_counter} + 65'(i)) < IMEM_LIMIT) begin
                fbyte[i] = imem[AW'(pc_counter + 64'(i))];
            end else begin
                fbyte[i] = 8'h00;
            end
        end
    end

    logic [3:0]  raw_icode;
    logic [3:0]  raw_ifun;
    logic        byte0_oob;
    logic [3:0]  len;
    logic [64:0] last_addr;

    assign raw_icode = fbyte[0][7:4];
    assign raw_ifun  = fbyte[0][3:0];
    assign byte0_oob = {1'b0, pc_counter} >= IMEM_LIMIT;
    assign len       = byte0_oob ? LEN_1 : instr_len(raw_icode);
    // 65-bit so an instruction straddling 2^64 is still caught rather than wrapping.
    assign last_addr = {1'b0, pc_counter} + 65'(len) - 65'd1;
    assign imem_error = last_addr >= IMEM_LIMIT;

    always_comb begin
        icode = raw_icode;
        ifun  = raw_ifun;
        ra    = RNONE;
        rb    = RNONE;
        valc  = 64'd0;
        valp  = pc_counter + 64'(len);
        if (imem_error) begin
            // A faulting fetch is presented downstream as a one-byte nop.
            icode = INOP;
            ifun  = 4'h0;
            valp  = pc_counter + 64'd1;
        end else begin
            case (raw_icode)
                IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: begin
                    ra = fbyte[1][7:4];
                    rb = fbyte[1][3:0];
                end
                IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
                    ra   = fbyte[1][7:4];
                    rb   = fbyte[1][3:0];
                    valc = {fbyte[9], fbyte[8], fbyte[7], fbyte[6],
                            fbyte[5], fbyte[4], fbyte[3], fbyte[2]};
                end
                IJXX, ICALL: begin
                    valc = {fbyte[8], fbyte[7], fbyte[6], fbyte[5],
                            fbyte[4], fbyte[3], fbyte[2], fbyte[1]};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (icode)
            IRRMOVQ, IJXX: instruction_valid = (ifun <= 4'd6);
            IOPQ:          instruction_valid = (ifun <= 4'd3);
            IHALT, INOP, IIRMOVQ, IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ:
                           instruction_valid = (ifun == 4'h0);
            default:       instruction_valid = 1'b0;
        endcase
    end

    assign halt = (icode == IHALT) && !imem_error;

    // ---------------------------------------------------------------- decode
    // Entry 15 (RNONE) reads as zero.
    logic [63:0] regs [16];

    always_comb begin
        regs[0]  = r0;
        regs[1]  = r1;
        regs[2]  = r2;
        regs[3]  = r3;
        regs[4]  = r4;
        regs[5]  = r5;
        regs[6]  = r6;
        regs[7]  = r7;
        regs[8]  = r8;
        regs[9]  = r9;
        regs[10] = r10;
        regs[11] = r11;
        regs[12] = r12;
        regs[13] = r13;
        regs[14] = r14;
        regs[15] = 64'd0;
    end

    always_comb begin
        case (icode)
            IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: vala = regs[ra];
            IRET, IPOPQ:                    vala = regs[RSP];
            default:                        vala = 64'd0;
        endcase
        case (icode)
            IRMMOVQ, IMRMOVQ, IOPQ:         valb = regs[rb];
            ICALL, IRET, IPUSHQ, IPOPQ:     valb = regs[RSP];
            default:                        valb = 64'd0;
        endcase
    end

    // ---------------------------------------------------------------- execute
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    alu_fn_e     alu_fn;
    logic        alu_of;
    logic        alu_sf;
    logic        alu_zf;

    always_comb begin
        case (icode)
            IRRMOVQ, IOPQ:              alu_a = vala;
            IIRMOVQ, IRMMOVQ, IMRMOVQ:  alu_a = valc;
            ICALL, IPUSHQ:              alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
            IRET, IPOPQ:                alu_a = 64'd8;
            default:                    alu_a = 64'd0;
        endcase
        case (icode)
            IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ: alu_b = valb;
            default:                                            alu_b = 64'd0;
        endcase
        // Illegal OPq ifun falls back to add; CC is not updated for it anyway.
        if (icode == IOPQ && ifun <= 4'd3) begin
            alu_fn = alu_fn_e'(ifun[1:0]);
        end else begin
            alu_fn = AluAdd;
        end
    end

    y86_alu u_alu (
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .fn     (alu_fn),
        .result (vale),
        .of     (alu_of),
        .sf     (alu_sf),
        .zf     (alu_zf)
    );

    // ---------------------------------------------------------------- condition codes
    logic zf_q;
    logic sf_q;
    logic of_q;
    logic cc_we;

    assign cc_we = (icode == IOPQ) && instruction_valid && !imem_error;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            zf_q <= 1'b1;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else if (cc_we) begin
            zf_q <= alu_zf;
            sf_q <= alu_sf;
            of_q <= alu_of;
        end
    end

    assign zero_flag     = zf_q;
    assign sign_flag     = sf_q;
    assign overflow_flag = of_q;

    assign condition_cnd = (icode == IRRMOVQ || icode == IJXX) ?
                           cond_eval(ifun, zf_q, sf_q, of_q) : 1'b1;

endmodule

// File: tb/tb_y86_seq_fde.sv
// Directed bench for y86_seq_fde: loads a small program, then walks pc through it
// checking fetched fields, operands, ALU result, condition and flags.
module tb_y86_seq_fde;

    localparam int unsigned IMEM_BYTES = 1024;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_we = 1'b0;
    logic [63:0] imem_waddr = 64'd0;
    logic [7:0]  imem_wdata = 8'd0;
    logic [63:0] pc_counter = 64'd0;
    logic [63:0] r0, r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, r11, r12, r13, r14;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp, vala, valb, vale;
    logic        condition_cnd, overflow_flag, sign_flag, zero_flag;
    logic        instruction_valid, imem_error, halt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    y86_seq_fde #(.IMEM_BYTES(IMEM_BYTES)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .imem_we           (imem_we),
        .imem_waddr        (imem_waddr),
        .imem_wdata        (imem_wdata),
        .pc_counter        (pc_counter),
        .r0                (r0),
        .r1                (r1),
        .r2                (r2),
        .r3                (r3),
        .r4                (r4),
        .r5                (r5),
        .r6                (r6),
        .r7                (r7),
        .r8                (r8),
        .r9                (r9),
        .r10               (r10),
        .r11               (r11),
        .r12               (r12),
        .r13               (r13),
        .r14               (r14),
        .icode             (icode),
        .ifun              (ifun),
        .ra                (ra),
        .rb                (rb),
        .valc              (valc),
        .valp              (valp),
        .vala              (vala),
        .valb              (valb),
        .vale              (vale),
        .condition_cnd     (condition_cnd),
        .overflow_flag     (overflow_flag),
        .sign_flag         (sign_flag),
        .zero_flag         (zero_flag),
        .instruction_valid (instruction_valid),
        .imem_error        (imem_error),
        .halt              (halt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [63:0] addr, input logic [7:0] data);
        imem_we    = 1'b1;
        imem_waddr = addr;
        imem_wdata = data;
        @(posedge clock);
        #1;
        imem_we = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_pc(input logic [63:0] pc);
        pc_counter = pc;
        #1;
    endtask

    // Program at address 0
    logic [7:0] prog [41] = '{
        8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, // 0  irmovq $10,%rdx
        8'h60, 8'h03,                                                         // 10 addq %rax,%rbx
        8'h61, 8'h00,                                                         // 12 subq %rax,%rax
        8'h74, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,        // 14 jne 0x20
        8'h73, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,        // 23 je 0x20
        8'h60, 8'h01,                                                         // 32 addq %rax,%rcx
        8'hA0, 8'h0F,                                                         // 34 pushq %rax
        8'h90,                                                                // 36 ret
        8'hC0,                                                                // 37 illegal
        8'h00,                                                                // 38 halt
        8'h64, 8'h00                                                          // 39 OPq ifun 4
    };

    initial begin
        r0 = 64'd12;   r1 = 64'd25;   r2 = 64'd38;   r3 = 64'd87;   r4 = 64'd10;
        r5 = 64'd45;   r6 = 64'd33;   r7 = 64'd145;  r8 = 64'd345;  r9 = 64'd420;
        r10 = 64'd1034; r11 = 64'd44; r12 = 64'd3;   r13 = 64'd11;  r14 = 64'd7;

        // Load while held in reset so CC cannot move.
        for (int i = 0; i < 41; i++) wr(64'(i), prog[i]);
        wr(64'(IMEM_BYTES - 1), 8'h30);

        chk("reset_zf", 64'(zero_flag), 64'd1);
        chk("reset_sf", 64'(sign_flag), 64'd0);
        chk("reset_of", 64'(overflow_flag), 64'd0);

        set_pc(64'd0);
        reset_n = 1'b1;
        #1;

        // 1. irmovq
        chk("irm_icode", 64'(icode), 64'h3);
        chk("irm_ra", 64'(ra), 64'hF);
        chk("irm_rb", 64'(rb), 64'h2);
        chk("irm_valc", valc, 64'd10);
        chk("irm_valp", valp, 64'd10);
        chk("irm_vale", vale, 64'd10);
        chk("irm_cnd", 64'(condition_cnd), 64'd1);
        chk("irm_valid", 64'(instruction_valid), 64'd1);
        tick();
        chk("irm_no_cc", 64'(zero_flag), 64'd1);

        // 2. addq %rax,%rbx
        set_pc(64'd10);
        chk("add_vala", vala, 64'd12);
        chk("add_valb", valb, 64'd87);
        chk("add_vale", vale, 64'd99);
        chk("add_valp", valp, 64'd12);
        tick();
        chk("add_zf", 64'(zero_flag), 64'd0);
        chk("add_sf", 64'(sign_flag), 64'd0);
        chk("add_of", 64'(overflow_flag), 64'd0);

        // 3. subq %rax,%rax then jne / je
        set_pc(64'd12);
        chk("sub_vale", vale, 64'd0);
        tick();
        chk("sub_zf", 64'(zero_flag), 64'd1);
        set_pc(64'd14);
        chk("jne_cnd", 64'(condition_cnd), 64'd0);
        chk("jne_valc", valc, 64'h20);
        chk("jne_valp", valp, 64'd23);
        set_pc(64'd23);
        chk("je_cnd", 64'(condition_cnd), 64'd1);

        // 4. signed overflow on add
        r0 = 64'h7FFF_FFFF_FFFF_FFFF;
        r1 = 64'd1;
        set_pc(64'd32);
        chk("ovf_vale", vale, 64'h8000_0000_0000_0000);
        tick();
        chk("ovf_of", 64'(overflow_flag), 64'd1);
        chk("ovf_sf", 64'(sign_flag), 64'd1);
        chk("ovf_zf", 64'(zero_flag), 64'd0);
        set_pc(64'd14);
        chk("jne_taken", 64'(condition_cnd), 64'd1);
        r0 = 64'd12;
        r1 = 64'd25;

        // 5. pushq / ret
        set_pc(64'd34);
        chk("push_vala", vala, 64'd12);
        chk("push_valb", valb, 64'd10);
        chk("push_vale", vale, 64'd2);
        chk("push_valp", valp, 64'd36);
        set_pc(64'd36);
        chk("ret_vala", vala, 64'd10);
        chk("ret_valb", valb, 64'd10);
        chk("ret_vale", vale, 64'd18);
        chk("ret_valp", valp, 64'd37);

        // 6. illegal icode, halt, illegal OPq leaves CC alone, fetch past end
        set_pc(64'd37);
        chk("c0_valid", 64'(instruction_valid), 64'd0);
        set_pc(64'd38);
        chk("halt", 64'(halt), 64'd1);
        chk("halt_valp", valp, 64'd39);
        set_pc(64'd39);
        chk("opq4_valid", 64'(instruction_valid), 64'd0);
        tick();
        chk("opq4_sf_kept", 64'(sign_flag), 64'd1);
        chk("opq4_of_kept", 64'(overflow_flag), 64'd1);
        set_pc(64'(IMEM_BYTES - 1));
        chk("oob_err", 64'(imem_error), 64'd1);
        chk("oob_icode", 64'(icode), 64'h1);
        chk("oob_valp", valp, 64'(IMEM_BYTES));
        chk("oob_halt", 64'(halt), 64'd0);

        // Asynchronous reset mid-run
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_zf", 64'(zero_flag), 64'd1);
        chk("areset_sf", 64'(sign_flag), 64'd0);
        chk("areset_of", 64'(overflow_flag), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
